// File: rtl/sseg_scan_driver_if.sv
// Bus between the number-generation logic and the seven-segment scan driver.
//   load/data/err/dp_in/digit_en : value and masks, captured on the load strobe
//   sseg/dp/an                   : active-low pin drive towards the board
//   pending/frame_done           : buffer and frame status back to the producer
// master = producer of the value, slave = the scan driver.
interface sseg_scan_driver_if;
  logic        load;
  logic [15:0] data;
  logic        err;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  sseg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  modport master (
    output load, data, err, dp_in, digit_en,
    input  sseg, dp, an, pending, frame_done
  );

  modport slave (
    input  load, data, err, dp_in, digit_en,
    output sseg, dp, an, pending, frame_done
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver (BASYS-2).
// A loaded value sits in a pending buffer until the frame boundary, then moves
// to the active buffer that the scan reads, so a frame never mixes old and new
// digits. Each digit slot starts with BLANK_CYCLES of all-anodes-off.
//   clk1 : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   disp : slave side of sseg_scan_driver_if (load/data/err/dp_in/digit_en in,
//          sseg/dp/an/pending/frame_done out; pin outputs active-low, registered)
module sseg_scan_driver #(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic               clk1,
  input logic               rst,
  sseg_scan_driver_if.slave disp
);
  localparam int unsigned     OFF_W     = REFRESH_BITS - 2;
  localparam logic [OFF_W-1:0] BLANK_OFF = OFF_W'(BLANK_CYCLES);

  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_R = 7'b0101111;

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [15:0]             pdata_q, pdata_d, adata_q, adata_d;
  logic                    perr_q, perr_d, aerr_q, aerr_d;
  logic [3:0]              pdp_q, pdp_d, adp_q, adp_d;
  logic [3:0]              pen_q, pen_d, aen_q, aen_d;
  logic [6:0]              sseg_q, sseg_d;
  logic [3:0]              an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    fdone_q, fdone_d;

  logic             boundary;
  logic [1:0]       sel;
  logic [OFF_W-1:0] off;
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic             digit_on;

  assign boundary = &cnt_q;
  assign sel      = cnt_q[REFRESH_BITS-1 -: 2];
  assign off      = cnt_q[OFF_W-1:0];
  assign nib      = adata_q[{sel, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Buffer management
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    fdone_d   = boundary;
    pending_d = pending_q;
    pdata_d   = pdata_q;
    perr_d    = perr_q;
    pdp_d     = pdp_q;
    pen_d     = pen_q;
    adata_d   = adata_q;
    aerr_d    = aerr_q;
    adp_d     = adp_q;
    aen_d     = aen_q;
    if (disp.load) begin
      if (boundary) begin
        // Load on the boundary bypasses the pending stage entirely.
        adata_d   = disp.data;
        aerr_d    = disp.err;
        adp_d     = disp.dp_in;
        aen_d     = disp.digit_en;
        pending_d = 1'b0;
      end else begin
        pdata_d   = disp.data;
        perr_d    = disp.err;
        pdp_d     = disp.dp_in;
        pen_d     = disp.digit_en;
        pending_d = 1'b1;
      end
    end else if (boundary && pending_q) begin
      adata_d   = pdata_q;
      aerr_d    = perr_q;
      adp_d     = pdp_q;
      aen_d     = pen_q;
      pending_d = 1'b0;
    end
  end

  // Pin drive for the current slot
  always_comb begin
    if (aerr_q) begin
      glyph    = (sel == 2'd0) ? GLYPH_R : GLYPH_E;
      digit_on = aen_q[sel] && !sel[1];
    end else begin
      glyph    = hex7(nib);
      digit_on = aen_q[sel];
    end
    an_d   = '1;
    sseg_d = '1;
    dp_d   = 1'b1;
    if (digit_on && (off >= BLANK_OFF)) begin
      an_d[sel] = 1'b0;
      sseg_d    = glyph;
      dp_d      = aerr_q | ~adp_q[sel];
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pdata_q   <= '0;
      perr_q    <= 1'b0;
      pdp_q     <= '0;
      pen_q     <= '0;
      adata_q   <= '0;
      aerr_q    <= 1'b0;
      adp_q     <= '0;
      aen_q     <= '0;
      sseg_q    <= '1;
      an_q      <= '1;
      dp_q      <= 1'b1;
      fdone_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pdata_q   <= pdata_d;
      perr_q    <= perr_d;
      pdp_q     <= pdp_d;
      pen_q     <= pen_d;
      adata_q   <= adata_d;
      aerr_q    <= aerr_d;
      adp_q     <= adp_d;
      aen_q     <= aen_d;
      sseg_q    <= sseg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      fdone_q   <= fdone_d;
    end
  end

  assign disp.sseg       = sseg_q;
  assign disp.an         = an_q;
  assign disp.dp         = dp_q;
  assign disp.pending    = pending_q;
  assign disp.frame_done = fdone_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver with a 64-cycle frame (16-cycle slots, 2 blank).
// A reference model of the display buffers predicts every registered output
// each cycle; directed scenarios are followed by randomized loads.
module tb_sseg_scan_driver;
  localparam int unsigned RB    = 6;
  localparam int unsigned BL    = 2;
  localparam int          FRAME = 64;
  localparam int          SLOT  = 16;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  sseg_scan_driver_if disp ();

  sseg_scan_driver #(.REFRESH_BITS(RB), .BLANK_CYCLES(BL)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .disp (disp)
  );

  always #5 clk1 = ~clk1;

  logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;

  // Reference state
  int          m_cnt;
  logic        m_pend;
  logic [15:0] m_ad, m_pd;
  logic        m_ae, m_pe;
  logic [3:0]  m_adp, m_pdp, m_aen, m_pen;

  task automatic model_reset();
    m_cnt = 0; m_pend = 1'b0;
    m_ad = '0; m_pd = '0; m_ae = 1'b0; m_pe = 1'b0;
    m_adp = '0; m_pdp = '0; m_aen = '0; m_pen = '0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (model cnt %0d)", tag, obs, exp, m_cnt);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 16'(disp.an), 16'hF);
    chk({tag, "_sseg"}, 16'(disp.sseg), 16'h7F);
    chk({tag, "_dp"}, 16'(disp.dp), 16'h1);
    chk({tag, "_pending"}, 16'(disp.pending), 16'h0);
    chk({tag, "_frame_done"}, 16'(disp.frame_done), 16'h0);
  endtask

  // One clock: predict outputs from the pre-edge model state, advance the model
  // with the inputs present at the edge, then compare just after the edge.
  task automatic tick();
    int         dig, off;
    logic       lit;
    logic [6:0] g, e_ss;
    logic [3:0] e_an;
    logic       e_dp, e_fd;
    dig = m_cnt / SLOT;
    off = m_cnt % SLOT;
    if (m_ae) g = (dig == 1) ? 7'b0000110 : 7'b0101111;
    else      g = HEX[(m_ad >> (4 * dig)) & 16'hF];
    lit  = (off >= BL) && m_aen[dig] && !(m_ae && dig >= 2);
    e_an = 4'b1111; e_ss = 7'h7F; e_dp = 1'b1;
    if (lit) begin
      e_an = ~(4'b0001 << dig);
      e_ss = g;
      e_dp = m_ae ? 1'b1 : ~m_adp[dig];
    end
    e_fd = (m_cnt == FRAME - 1);
    if (disp.load) begin
      if (m_cnt == FRAME - 1) begin
        m_ad = disp.data; m_ae = disp.err; m_adp = disp.dp_in; m_aen = disp.digit_en;
        m_pend = 1'b0;
      end else begin
        m_pd = disp.data; m_pe = disp.err; m_pdp = disp.dp_in; m_pen = disp.digit_en;
        m_pend = 1'b1;
      end
    end else if (m_cnt == FRAME - 1 && m_pend) begin
      m_ad = m_pd; m_ae = m_pe; m_adp = m_pdp; m_aen = m_pen;
      m_pend = 1'b0;
    end
    m_cnt = (m_cnt + 1) % FRAME;
    @(posedge clk1);
    #1;
    chk("an", 16'(disp.an), 16'(e_an));
    chk("sseg", 16'(disp.sseg), 16'(e_ss));
    chk("dp", 16'(disp.dp), 16'(e_dp));
    chk("frame_done", 16'(disp.frame_done), 16'(e_fd));
    chk("pending", 16'(disp.pending), 16'(m_pend));
    chk("an_single", 16'($countones(~disp.an) <= 1), 16'h1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model-driven, so this always ends within one frame.
  task automatic run_to(input int c);
    while (m_cnt != c) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic e,
                         input logic [3:0] dpm, input logic [3:0] en);
    disp.load = 1'b1; disp.data = d; disp.err = e; disp.dp_in = dpm; disp.digit_en = en;
    tick();
    disp.load     = 1'b0;
    disp.data     = 16'($urandom);
    disp.err      = 1'($urandom);
    disp.dp_in    = 4'($urandom);
    disp.digit_en = 4'($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    disp.load = 1'b0; disp.data = '0; disp.err = 1'b0; disp.dp_in = '0; disp.digit_en = '0;
    model_reset();

    // Reset and idle display
    repeat (2) @(posedge clk1);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    run(200);

    // Load mid-frame, two digits enabled
    run_to(20);
    do_load(16'h0081, 1'b0, 4'b0000, 4'b0011);
    chk("pend_after_load", 16'(disp.pending), 16'h1);
    run_to(0);
    run(FRAME + 8);

    // Two loads in one frame: last wins
    run_to(10);
    do_load(16'h00A2, 1'b0, 4'b0001, 4'b0011);
    run_to(30);
    do_load(16'h00B6, 1'b0, 4'b0010, 4'b0011);
    run_to(0);
    run(2 * FRAME);

    // Error pattern with all dots requested
    do_load(16'h5A5A, 1'b1, 4'b1111, 4'b1111);
    run_to(0);
    run(FRAME + 4);

    // Load coincident with the frame boundary
    run_to(FRAME - 1);
    do_load(16'h0042, 1'b0, 4'b0000, 4'b0011);
    chk("pend_boundary_load", 16'(disp.pending), 16'h0);
    run(FRAME + 4);

    // Reset mid-slot with a load pending
    run_to(5);
    do_load(16'h1234, 1'b0, 4'b0101, 4'b1111);
    run_to(20);
    rst = 1'b1;
    #2;
    chk_reset_vals("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk1);
      #1;
      chk_reset_vals("rst_hold");
    end
    rst = 1'b0;
    model_reset();
    run(2 * FRAME + 10);

    // Randomized loads, including occasional boundary hits
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0 || (m_cnt == FRAME - 1 && $urandom_range(0, 3) == 0))
        do_load(16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
      else
        tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
